hex_scan_scheduler: RTL

Time-multiplexed scan controller that shares one active-low 4-bit-to-7-segment decoder among NUM_DIGITS common-anode digits. It accepts a packed hex value through a valid/ready handshake and applies it only at frame boundaries, so a frame never shows a mix of old and new digits. It drives the shared segment bus and one-hot-low digit enables, with inter-digit blanking, optional leading-zero suppression and per-digit blink. It sits between the value-producing logic (counters, ALU results) and the board's display pins.

---
 rtl/hex_scan_pkg.sv | 16 +
 rtl/hex_seg_lut.sv | 13 +
 rtl/hex_scan_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/hex_scan_pkg.sv
// Shared definitions for the multiplexed hex display scanner.
//   SEG_TABLE : active-low gfedcba patterns for nibbles 0..F
//   SEG_OFF   : all segments dark
//   slot_state_t : phase within one digit slot (dark guard, then lit)
package hex_scan_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {BLANK, DRIVE} slot_state_t;

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational nibble to active-low 7-segment decoder.
//   nib : hex digit value
//   seg : active-low segments, gfedcba
module hex_seg_lut
  import hex_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/hex_scan_scheduler.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits sharing
// one segment bus. New values arrive over valid/ready into a one-entry buffer
// and are only promoted to the displayed value at a frame boundary.
//   CLOCK_50   : clock, rising edge
//   reset      : synchronous, active-high
//   load_valid/load_ready/load_data : value handshake, nibble i = digit i
//   blank_lz   : suppress leading zeros (live)
//   blink_mask : digits dark during blink off-phase (live)
//   HEX_SEG    : active-low segments gfedcba (registered)
//   DIGIT_EN   : active-low one-hot digit enables (registered)
module hex_scan_scheduler
  import hex_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              HEX_SEG,
  output logic [NUM_DIGITS-1:0]   DIGIT_EN
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_MAX   = FW'(BLINK_FRAMES - 1);

  logic [4*NUM_DIGITS-1:0] disp;
  logic [4*NUM_DIGITS-1:0] pend;
  logic                    pend_full;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [FW-1:0]           frame_cnt;
  logic                    phase;

  slot_state_t             state;
  logic                    cnt_wrap;
  logic                    frame_end;
  logic                    accept;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic [3:0]              cur_nib;
  logic                    suppress;
  logic [6:0]              lut_seg;

  logic [6:0]              seg_p1;
  logic [NUM_DIGITS-1:0]   en_p1;

  assign load_ready = !pend_full;
  assign HEX_SEG    = seg_p1;
  assign DIGIT_EN   = en_p1;

  // Stage 0: slot decode, suppression and segment lookup from current idx/cnt/disp
  always_comb begin
    state     = (cnt < CNT_BLANK) ? BLANK : DRIVE;
    cnt_wrap  = (cnt == CNT_MAX);
    frame_end = cnt_wrap && (idx == IDX_MAX);
    accept    = load_valid && !pend_full;
  end

  // upper_zero[i]: nibbles NUM_DIGITS-1 down to i of disp are all zero
  always_comb begin
    logic z;
    z          = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z             = z && (disp[4*i +: 4] == 4'h0);
      upper_zero[i] = z;
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx) cur_nib = disp[4*i +: 4];
    end
  end

  // Digit 0 is exempt from leading-zero blanking so a zero value stays visible
  always_comb begin
    suppress = (state == BLANK)
            || (blank_lz && (idx != '0) && upper_zero[idx])
            || (blink_mask[idx] && phase);
  end

  hex_seg_lut u_lut (
    .nib (cur_nib),
    .seg (lut_seg)
  );

  // Stage 1: registered pin drive plus scan/frame/handshake state
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      disp      <= '0;
      pend_full <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
      seg_p1    <= SEG_OFF;
      en_p1     <= '1;
    end else begin
      seg_p1 <= suppress ? SEG_OFF : lut_seg;
      en_p1  <= suppress ? '1 : ~(NUM_DIGITS'(1) << idx);

      cnt <= cnt_wrap ? '0 : cnt + CW'(1);
      if (cnt_wrap) idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);

      if (frame_end) begin
        if (frame_cnt == FRM_MAX) begin
          frame_cnt <= '0;
          phase     <= !phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      // accept requires an empty buffer, so it never collides with a transfer;
      // a same-cycle accept at frame end waits for the following frame end
      if (frame_end && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end else if (accept) begin
        pend_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (accept) pend <= load_data;
  end

endmodule
